uart_rx: RTL and testbench

//  8N1 serial receiver, LSB first, idle-high line; counterpart of the team's uart transmitter.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, start-bit qualification, 3-sample mid-bit
// majority vote, show-ahead byte FIFO and sticky framing/overrun flags.
module uart_rx #(
  parameter int BIT_CLKS   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_,
  input  logic                               rx,
  input  logic                               re,
  output logic [7:0]                         rdata,
  output logic                               rvalid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               frame_err,
  output logic                               overrun,
  input  logic                               clr_err
);

  localparam int PHW = $clog2(BIT_CLKS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [PHW-1:0] PH_ZERO = {PHW{1'b0}};
  localparam logic [PHW-1:0] PH_ONE  = PHW'(1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(BIT_CLKS - 1);
  localparam logic [PHW-1:0] PH_PRE  = PHW'(BIT_CLKS / 2 - 1);
  localparam logic [PHW-1:0] PH_MID  = PHW'(BIT_CLKS / 2);
  localparam logic [PHW-1:0] PH_VOTE = PHW'(BIT_CLKS / 2 + 1);
  localparam logic [PW-1:0]  PTR_ONE = PW'(1);
  localparam logic [LW-1:0]  LVL_ONE = LW'(1);
  localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic           r_sync1, r_sync2;
  logic           r_smp_pre, r_smp_mid;
  state_t         r_state;
  logic [PHW-1:0] r_ph;
  logic [2:0]     r_bit;
  logic [7:0]     r_shreg;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [LW-1:0]  r_level;
  logic           r_frame_err, r_overrun;

  logic           w_at_vote, w_vote, w_push, w_ferr_set;
  logic           w_pop, w_full, w_wr, w_drop;
  logic [PHW-1:0] w_ph_next;

  assign w_ph_next  = (r_ph == PH_LAST) ? PH_ZERO : r_ph + PH_ONE;
  assign w_at_vote  = (r_ph == PH_VOTE);
  assign w_vote     = maj3(r_smp_pre, r_smp_mid, r_sync2);
  assign w_push     = (r_state == ST_STOP) && w_at_vote && w_vote;
  assign w_ferr_set = (r_state == ST_STOP) && w_at_vote && !w_vote;
  assign w_pop      = re && (r_level != {LW{1'b0}});
  assign w_full     = (r_level == LVL_FULL);
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;

  // Two-flop synchronizer and the two early vote samples.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_smp_pre <= 1'b1;
      r_smp_mid <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      if (r_ph == PH_PRE) r_smp_pre <= r_sync2;
      if (r_ph == PH_MID) r_smp_mid <= r_sync2;
    end
  end

  // Frame FSM with phase counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_ph    <= PH_ZERO;
      r_bit   <= 3'd0;
      r_shreg <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_sync2) begin
            r_state <= ST_START;
            r_ph    <= w_ph_next;
          end else begin
            r_ph <= PH_ZERO;
          end
        end
        ST_START: begin
          r_ph <= w_ph_next;
          if (w_at_vote) begin
            if (w_vote) begin
              r_state <= ST_IDLE;
              r_ph    <= PH_ZERO;
            end else begin
              r_state <= ST_DATA;
              r_bit   <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          r_ph <= w_ph_next;
          if (w_at_vote) begin
            r_shreg <= {w_vote, r_shreg[7:1]};
            if (r_bit == 3'd7) r_state <= ST_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end
        end
        ST_STOP: begin
          r_ph <= w_ph_next;
          if (w_at_vote) begin
            // Returning to IDLE at mid-stop lets the next start bit follow immediately.
            r_state <= w_vote ? ST_IDLE : ST_BREAK;
            r_ph    <= PH_ZERO;
          end
        end
        ST_BREAK: begin
          r_ph <= PH_ZERO;
          if (r_sync2) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ph    <= PH_ZERO;
        end
      endcase
    end
  end

  // Show-ahead FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_level <= {LW{1'b0}};
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_shreg;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_ferr_set)   r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
      if (w_drop)       r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
    end
  end

  assign rdata     = r_mem[r_rptr];
  assign rvalid    = (r_level != {LW{1'b0}});
  assign level     = r_level;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames, glitches,
// breaks and pops, checked against a byte-queue model of the receive FIFO and flags.
module tb_uart_rx;

  localparam int BIT_CLKS = 10;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       rx = 1'b1;
  logic       re = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [2:0] level;
  logic       frame_err;
  logic       overrun;

  int         n_chk = 0;
  int         n_pass = 0;

  logic [7:0] q[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;

  uart_rx #(.BIT_CLKS(BIT_CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_), .rx(rx), .re(re), .rdata(rdata), .rvalid(rvalid),
    .level(level), .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  // Drives nper bit periods of a frame; one clock at (gl_per, gl_ph) is inverted.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gl_per,
                            input int gl_ph, input int nper);
    logic [9:0] bits;
    bits = {stop_ok ? 1'b1 : 1'b0, d, 1'b0};
    for (int p = 0; p < nper; p++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        rx = (p == gl_per && c == gl_ph) ? ~bits[p] : bits[p];
        tick(1);
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop_ok);
    if (!stop_ok)                exp_ferr = 1'b1;
    else if (q.size() == DEPTH)  exp_ovr = 1'b1;
    else                         q.push_back(d);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".level"}, {29'd0, level}, q.size());
    check_eq({tag, ".rvalid"}, {31'd0, rvalid}, (q.size() != 0) ? 32'd1 : 32'd0);
    check_eq({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, exp_ferr});
    check_eq({tag, ".overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
    if (q.size() != 0) check_eq({tag, ".rdata"}, {24'd0, rdata}, {24'd0, q[0]});
  endtask

  task automatic pop_check(input string tag);
    if (q.size() != 0) begin
      check_eq({tag, ".pop_valid"}, {31'd0, rvalid}, 32'd1);
      check_eq({tag, ".pop_data"}, {24'd0, rdata}, {24'd0, q[0]});
      void'(q.pop_front());
    end else begin
      check_eq({tag, ".empty_valid"}, {31'd0, rvalid}, 32'd0);
    end
    re = 1'b1;
    tick(1);
    re = 1'b0;
    check_eq({tag, ".after_pop_level"}, {29'd0, level}, q.size());
  endtask

  task automatic drain(input string tag);
    while (q.size() != 0) pop_check(tag);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".rvalid"}, {31'd0, rvalid}, 32'd0);
    check_eq({tag, ".rdata"}, {24'd0, rdata}, 32'd0);
    check_eq({tag, ".level"}, {29'd0, level}, 32'd0);
    check_eq({tag, ".frame_err"}, {31'd0, frame_err}, 32'd0);
    check_eq({tag, ".overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    tick(3);
    check_reset_outputs("reset");
    rst_ = 1'b1;
    idle(5);

    // Clean frame; push lands one edge after the stop-bit vote (ph=H+1 of period 9).
    fork
      send_frame(8'hA5, 1'b1, -1, 0, 10);
      begin
        repeat (98) @(posedge clk);
        #1;
        check_eq("t1.rvalid_before_vote", {31'd0, rvalid}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("t1.rvalid_after_vote", {31'd0, rvalid}, 32'd1);
      end
    join
    model_frame(8'hA5, 1'b1);
    check_state("t1");
    drain("t1");

    // Short low pulse while idle is a false start.
    rx = 1'b0;
    tick(3);
    idle(20);
    check_state("t2.glitch");
    send_frame(8'h3C, 1'b1, -1, 0, 10);
    model_frame(8'h3C, 1'b1);
    check_state("t2.frame");
    drain("t2");

    // Single-clock flip at mid-bit of data bit 3 is outvoted.
    send_frame(8'h00, 1'b1, 4, BIT_CLKS / 2, 10);
    model_frame(8'h00, 1'b1);
    check_state("t3");
    drain("t3");

    // Low stop bit, line held low, then a good frame and an error clear.
    send_frame(8'h81, 1'b0, -1, 0, 10);
    model_frame(8'h81, 1'b0);
    rx = 1'b0;
    tick(30);
    check_state("t4.break");
    idle(5);
    send_frame(8'h42, 1'b1, -1, 0, 10);
    model_frame(8'h42, 1'b1);
    check_state("t4.after");
    drain("t4");
    clear_errors();
    check_state("t4.clr");

    // Five bytes into a four-deep FIFO without popping.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, 0, 10);
      model_frame(8'(i), 1'b1);
      idle(3);
    end
    check_state("t5.full");
    drain("t5a");
    pop_check("t5a.empty");
    clear_errors();
    check_state("t5.clr");

    // Same, but the head is popped on the exact edge of the fifth push.
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, -1, 0, 10);
      model_frame(8'(i), 1'b1);
      idle(3);
    end
    fork
      send_frame(8'h05, 1'b1, -1, 0, 10);
      begin
        repeat (98) @(posedge clk);
        #1;
        check_eq("t5b.head", {24'd0, rdata}, {24'd0, q[0]});
        re = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
        void'(q.pop_front());
      end
    join
    model_frame(8'h05, 1'b1);
    check_state("t5b");
    drain("t5b");

    // Back-to-back frames with no idle between them.
    send_frame(8'h00, 1'b1, -1, 0, 10);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, -1, 0, 10);
    model_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1, -1, 0, 10);
    model_frame(8'h55, 1'b1);
    check_state("t6.b2b");
    drain("t6");

    // Reset in the middle of a frame with a byte already buffered.
    send_frame(8'h77, 1'b1, -1, 0, 10);
    model_frame(8'h77, 1'b1);
    send_frame(8'h99, 1'b1, -1, 0, 5);
    rst_ = 1'b0;
    rx = 1'b1;
    tick(3);
    check_reset_outputs("t6.rst");
    q.delete();
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    rst_ = 1'b1;
    idle(5);
    send_frame(8'h5A, 1'b1, -1, 0, 10);
    model_frame(8'h5A, 1'b1);
    check_state("t6.after_rst");
    drain("t6r");

    // Randomized frames, glitches, breaks, pops and clears.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit         ok;
      int         gp, gh, npop;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      gp = $urandom_range(0, 9);
      gh = (gp == 0) ? $urandom_range(1, BIT_CLKS - 1) : $urandom_range(0, BIT_CLKS - 1);
      if (gp == 9) gp = -1;
      if ($urandom_range(0, 5) == 0) begin
        rx = 1'b0;
        tick(1);
        idle(15);
      end
      send_frame(d, ok, gp, gh, 10);
      model_frame(d, ok);
      if (!ok) begin
        rx = 1'b0;
        tick($urandom_range(0, 20));
        idle($urandom_range(2, 12));
      end else begin
        idle($urandom_range(0, 12));
      end
      check_state("rnd");
      npop = $urandom_range(0, q.size());
      for (int k = 0; k < npop; k++) pop_check("rnd");
      if ($urandom_range(0, 3) == 0) begin
        clear_errors();
        check_state("rnd.clr");
      end
    end
    drain("rnd.end");
    check_state("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
